// File: rtl/seg7_scan_driver_if.sv
// Bus bundle for the four-digit seven-segment scan driver: frame data load
// side from the host and the multiplexed segment/anode drive toward the display.
interface seg7_scan_driver_if;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lzs_en;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    modport master (
        output load, digits_in, dp_in, blank_in, lzs_en,
        input  seg, an, frame_start
    );

    modport slave (
        input  load, digits_in, dp_in, blank_in, lzs_en,
        output seg, an, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a four-digit common-anode seven-segment display
// with double-buffered frame data, blank gaps between digits and leading-zero suppression.
module seg7_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input logic               clk,
    input logic               reset,
    seg7_scan_driver_if.slave bus
);
    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [0:0]       state_r, state_nxt_s;
    logic [1:0]       idx_r, idx_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             xfer_s;

    logic [15:0] act_digits_r, act_digits_nxt_s, pend_digits_r;
    logic [3:0]  act_dp_r, act_dp_nxt_s, pend_dp_r;
    logic [3:0]  act_blank_r, act_blank_nxt_s, pend_blank_r;
    logic        pend_valid_r;

    logic [7:0]  seg_r, seg_nxt_s;
    logic [3:0]  an_r, an_nxt_s;
    logic        frame_start_r;
    logic [3:0]  nib_s;
    logic        supp_s;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_decode = 7'b0000001;
            4'h1:    seg_decode = 7'b1001111;
            4'h2:    seg_decode = 7'b0010010;
            4'h3:    seg_decode = 7'b0000110;
            4'h4:    seg_decode = 7'b1001100;
            4'h5:    seg_decode = 7'b0100100;
            4'h6:    seg_decode = 7'b0100000;
            4'h7:    seg_decode = 7'b0001111;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0000100;
            4'hA:    seg_decode = 7'b0001000;
            4'hB:    seg_decode = 7'b1100000;
            4'hC:    seg_decode = 7'b0110001;
            4'hD:    seg_decode = 7'b1000010;
            4'hE:    seg_decode = 7'b0110000;
            4'hF:    seg_decode = 7'b0111000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Slot sequencer: SHOW/BLANK alternation, digit index advance and frame transfer point.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        xfer_s      = 1'b0;
        case (state_r)
            ST_SHOW: begin
                if (cnt_r == SHOW_LAST) begin
                    state_nxt_s = ST_BLANK;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = ST_SHOW;
                end
            end
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_nxt_s = ST_SHOW;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    idx_nxt_s   = idx_r + 2'd1;
                    xfer_s      = (idx_r == 2'd3);
                end else begin
                    state_nxt_s = ST_BLANK;
                end
            end
            default: begin
                state_nxt_s = ST_BLANK;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Active frame data only changes when a new frame begins on digit0.
    always_comb begin
        if (xfer_s && pend_valid_r) begin
            act_digits_nxt_s = pend_digits_r;
            act_dp_nxt_s     = pend_dp_r;
            act_blank_nxt_s  = pend_blank_r;
        end else begin
            act_digits_nxt_s = act_digits_r;
            act_dp_nxt_s     = act_dp_r;
            act_blank_nxt_s  = act_blank_r;
        end
    end

    // Output drive computed from next-cycle state so the registers track it with no lag.
    always_comb begin
        nib_s = act_digits_nxt_s[{idx_nxt_s, 2'b00} +: 4];
        case (idx_nxt_s)
            2'd3:    supp_s = (act_digits_nxt_s[15:12] == 4'h0);
            2'd2:    supp_s = (act_digits_nxt_s[15:8] == 8'h00);
            2'd1:    supp_s = (act_digits_nxt_s[15:4] == 12'h000);
            default: supp_s = 1'b0;
        endcase
        supp_s = supp_s & bus.lzs_en;
        if ((state_nxt_s == ST_SHOW) && !act_blank_nxt_s[idx_nxt_s]) begin
            an_nxt_s  = ~(4'b0001 << idx_nxt_s);
            seg_nxt_s = {(supp_s ? 7'b1111111 : seg_decode(nib_s)), ~act_dp_nxt_s[idx_nxt_s]};
        end else begin
            an_nxt_s  = 4'b1111;
            seg_nxt_s = 8'hFF;
        end
    end

    // State, buffers and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_BLANK;
            idx_r         <= 2'd3;
            cnt_r         <= {CNT_W{1'b0}};
            act_digits_r  <= 16'h0000;
            act_dp_r      <= 4'h0;
            act_blank_r   <= 4'h0;
            pend_digits_r <= 16'h0000;
            pend_dp_r     <= 4'h0;
            pend_blank_r  <= 4'h0;
            pend_valid_r  <= 1'b0;
            seg_r         <= 8'hFF;
            an_r          <= 4'b1111;
            frame_start_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            idx_r         <= idx_nxt_s;
            cnt_r         <= cnt_nxt_s;
            act_digits_r  <= act_digits_nxt_s;
            act_dp_r      <= act_dp_nxt_s;
            act_blank_r   <= act_blank_nxt_s;
            seg_r         <= seg_nxt_s;
            an_r          <= an_nxt_s;
            frame_start_r <= xfer_s;
            // A load coinciding with the transfer is kept as the next pending frame.
            if (bus.load) begin
                pend_digits_r <= bus.digits_in;
                pend_dp_r     <= bus.dp_in;
                pend_blank_r  <= bus.blank_in;
                pend_valid_r  <= 1'b1;
            end else if (xfer_s) begin
                pend_valid_r  <= 1'b0;
            end else begin
                pend_valid_r  <= pend_valid_r;
            end
        end
    end

    assign bus.seg         = seg_r;
    assign bus.an          = an_r;
    assign bus.frame_start = frame_start_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a time-position reference model.
module tb_seg7_scan_driver;
    localparam int SD  = 4;
    localparam int BC  = 2;
    localparam int SL  = SD + BC;
    localparam int PER = 4 * SL;

    logic clk;
    logic reset;
    seg7_scan_driver_if bus_if();

    seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] dec_tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int unsigned n_edges = 0;
    int          cur_phase = 0;
    logic [15:0] m_dig = 16'h0, p_dig = 16'h0;
    logic [3:0]  m_dp = 4'h0, p_dp = 4'h0, m_bl = 4'h0, p_bl = 4'h0;
    bit          p_v = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic tick();
        logic       rst_smp, lzs_smp;
        int         slot, w;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic       e_fs;
        logic [15:0] hi;
        @(posedge clk);
        rst_smp = reset;
        lzs_smp = bus_if.lzs_en;
        if (rst_smp) begin
            n_edges = 0;
            m_dig = 16'h0; m_dp = 4'h0; m_bl = 4'h0;
            p_dig = 16'h0; p_dp = 4'h0; p_bl = 4'h0; p_v = 1'b0;
        end else begin
            n_edges++;
            if ((n_edges + PER - BC) % PER == 0 && p_v) begin
                m_dig = p_dig; m_dp = p_dp; m_bl = p_bl; p_v = 1'b0;
            end
            if (bus_if.load) begin
                p_dig = bus_if.digits_in; p_dp = bus_if.dp_in; p_bl = bus_if.blank_in; p_v = 1'b1;
            end
        end
        cur_phase = (n_edges + PER - BC) % PER;
        slot = cur_phase / SL;
        w    = cur_phase % SL;
        e_an = 4'b1111; e_seg = 8'hFF; e_fs = 1'b0;
        if (!rst_smp) begin
            e_fs = (cur_phase == 0);
            if (w < SD && !m_bl[slot]) begin
                e_an = ~(4'b0001 << slot);
                hi   = m_dig >> (4 * slot);
                e_seg = {((lzs_smp && slot > 0 && hi == 16'h0) ? 7'b1111111 : dec_tbl[hi[3:0]]),
                         ~m_dp[slot]};
            end
        end
        #1;
        check_val("an", {28'h0, bus_if.an}, {28'h0, e_an});
        check_val("seg", {24'h0, bus_if.seg}, {24'h0, e_seg});
        check_val("frame_start", {31'h0, bus_if.frame_start}, {31'h0, e_fs});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        bus_if.load = 1'b1; bus_if.digits_in = d; bus_if.dp_in = dp; bus_if.blank_in = bl;
        tick();
        bus_if.load = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus_if.load = 1'b0; bus_if.digits_in = 16'h0; bus_if.dp_in = 4'h0;
        bus_if.blank_in = 4'h0; bus_if.lzs_en = 1'b0;
        run(3);
        reset = 1'b0;
        run(2 * PER);
        // Explicit spot check of the first digit0 slot of the first frame after reset.
        reset = 1'b1; tick(); reset = 1'b0;
        run(2);
        check_val("first_digit0_seg", {24'h0, bus_if.seg}, {24'h0, 8'b00000011});
        check_val("first_digit0_an", {28'h0, bus_if.an}, {28'h0, 4'b1110});

        do_load(16'h1234, 4'h0, 4'h0);
        run(2 * PER);
        for (int i = 0; i < PER && !(cur_phase >= SL && cur_phase < SL + SD); i++) tick();
        do_load(16'h5678, 4'h0, 4'h0);
        run(2 * PER);

        bus_if.lzs_en = 1'b1;
        do_load(16'h0050, 4'b1000, 4'h0);
        run(2 * PER);
        do_load(16'h0000, 4'b0001, 4'b0100);
        run(2 * PER);
        do_load(16'hABCD, 4'b0001, 4'b0100);
        for (int i = 0; i < PER && !(cur_phase >= 2 * SL && cur_phase < 2 * SL + SD); i++) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        run(2 * PER);

        for (int i = 0; i < 4000; i++) begin
            bus_if.load      = ($urandom_range(0, 15) == 0);
            bus_if.digits_in = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            bus_if.dp_in     = 4'($urandom);
            bus_if.blank_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 40) == 0) bus_if.lzs_en = ~bus_if.lzs_en;
            reset = ($urandom_range(0, 400) == 0);
            tick();
        end
        reset = 1'b0; bus_if.load = 1'b0;
        run(PER);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles each digit is driven (SHOW slot); legal range >= 2.
REQ-002 Parameter BLANK_CYC, default 500: clk cycles all anodes are off between digit slots (anti-ghost gap); legal range >= 1.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-005 load  input  1  single-cycle strobe; captures digits_in, dp_in and blank_in into the pending register.
REQ-006 digits_in  input  16  four hex nibbles; [3:0] is digit0 (rightmost), [15:12] is digit3.
REQ-007 dp_in  input  4  decimal-point request per digit; bit i maps to digit i.
REQ-008 blank_in  input  4  force digit i fully dark (anode off) when bit i = 1.
REQ-009 lzs_en  input  1  leading-zero suppression enable; sampled live, not latched by load.
REQ-010 seg  output  8  registered, active-low segments, seg[7]=a ... seg[1]=g, seg[0]=dp.
REQ-011 an  output  4  registered, active-low anodes, an[i] drives digit i.
REQ-012 frame_start  output  1  registered, one-cycle pulse in the first SHOW cycle of digit0.

Function
REQ-013 The FSM SHALL have two states: BLANK and SHOW, plus a 2-bit digit index idx and a slot counter cnt.
REQ-014 SHOW SHALL last exactly SCAN_DIV cycles, then go to BLANK with cnt=0 and idx unchanged.
REQ-015 BLANK SHALL last exactly BLANK_CYC cycles, then go to SHOW with cnt=0 and idx=idx+1 mod 4 (3 wraps to 0).
REQ-016 In BLANK, an SHALL be 4'b1111 and seg SHALL be 8'hFF.
REQ-017 In SHOW, an SHALL be all ones except an[idx]=0, unless active blank bit idx=1, which forces an=4'b1111 and seg=8'hFF.
REQ-018 Outputs SHALL be registered and SHALL change on the same edge as the state/idx they reflect (no extra cycle of lag).
REQ-019 Segment decode of nibble to seg[7:1]: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-020 seg[0] SHALL be ~active dp bit idx.
REQ-021 load SHALL write the pending register and set pending_valid; a later load before transfer overwrites it (last load wins).
REQ-022 On the BLANK->SHOW transition into idx=0, if pending_valid, the active register SHALL take the pending values and pending_valid SHALL clear; digits never change mid-frame.
REQ-023 load in the same cycle as the transfer: the transfer uses the old pending contents, the new data becomes pending and pending_valid stays 1.
REQ-024 frame_start SHALL be 1 exactly in the first SHOW cycle of idx=0, every frame, regardless of pending_valid.
REQ-025 With lzs_en=1, digit i (i=3,2,1) SHALL be suppressed when active nibbles i..3 are all zero; digit0 is never suppressed.
REQ-026 A suppressed digit SHALL drive seg[7:1]=7'b1111111 with its anode still active and dp still per dp bit.
REQ-027 Frame period SHALL be 4*(SCAN_DIV+BLANK_CYC) cycles.

Reset
REQ-028 While reset=1: state=BLANK, idx=3, cnt=0, an=4'b1111, seg=8'hFF, frame_start=0, active and pending digits=0, active dp=0, active blank=0, pending_valid=0.
REQ-029 Reset SHALL override load and any state; reset asserted mid-SHOW SHALL darken outputs on the next edge.
REQ-030 After reset release, the first SHOW slot SHALL be digit0 after exactly BLANK_CYC BLANK cycles.

Verification (SCAN_DIV=4, BLANK_CYC=2)
REQ-031 Release reset, no load -> 2 cycles an=1111/seg=FF; then frame_start=1, an=1110, seg=8'b00000011 for 4 cycles; frame repeats every 24 cycles.
REQ-032 load digits_in=16'h1234, dp_in=0 before a frame -> slots show an=1110 seg=10011001, an=1101 seg=00001101, an=1011 seg=00100101, an=0111 seg=10011111.
REQ-033 load 16'h5678 during digit1 SHOW -> rest of frame still shows 1234; next frame_start onward shows 5678.
REQ-034 active 16'h0050, lzs_en=1, dp_in=4'b1000 -> digit3 seg=11111110 an=0111, digit2 seg=FF an=1011, digit1 shows 5, digit0 shows 0.
REQ-035 blank_in=4'b0100 -> digit2 slot an=1111 seg=FF for 4 cycles; other slots unaffected; dp_in=4'b0001 -> digit0 seg[0]=0.
REQ-036 reset pulsed 1 cycle mid-digit2 SHOW -> an=1111/seg=FF next edge, active data cleared to 0, first SHOW after 2 BLANK cycles is digit0 with frame_start=1.
